// File: rtl/acc_pkg.sv
// Shared types, mode selectors and signed-range helpers for the accumulator.
package acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  localparam int unsigned ACC_WRAP = 0;
  localparam int unsigned ACC_SAT  = 1;

  // Largest value representable in a w-bit two's-complement word.
  function automatic longint smax(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a w-bit two's-complement word.
  function automatic longint smin(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/signed_add_ovf_w.sv
// Combinational W-bit two's-complement adder with signed overflow flag.
module signed_add_ovf_w #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);

  assign sum      = a + b;
  // Same-sign addends whose result flips sign have left the representable range.
  assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/signed_accumulate_with_overflow.sv
// Frame-based signed accumulator with sticky overflow, optional saturation and sample count.
module signed_accumulate_with_overflow
  import acc_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned CW       = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_overflow,
  output logic [CW-1:0] out_count
);

  localparam logic [W-1:0] SMax = W'(smax(W));
  localparam logic [W-1:0] SMin = W'(smin(W));

  acc_state_t    r_state, w_state_next;
  logic [W-1:0]  r_acc, w_acc_next, w_raw, w_fold;
  logic          r_ovf, w_ovf_next, w_add_ovf;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_in_ready, r_out_valid;
  logic          w_accept;

  // in_ready is registered, so the handshake needs no combinational path from in_valid.
  assign w_accept = in_valid & r_in_ready;

  signed_add_ovf_w #(
    .W (W)
  ) u_add (
    .a        (r_acc),
    .b        (in_data),
    .sum      (w_raw),
    .overflow (w_add_ovf)
  );

  // Clamp mux: on overflow both addends share the accumulator's sign, which picks the rail.
  always_comb begin
    w_fold = w_raw;
    if (SATURATE == ACC_SAT && w_add_ovf) begin
      w_fold = r_acc[W-1] ? SMin : SMax;
    end
  end

  // Next-state logic for the FSM and the accumulator registers.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ACC: begin
        if (w_accept) begin
          w_acc_next = w_fold;
          w_ovf_next = r_ovf | w_add_ovf;
          w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
          if (in_last) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_acc_next   = '0;
          w_ovf_next   = 1'b0;
          w_cnt_next   = '0;
          w_state_next = ACC;
        end
      end
      default: w_state_next = ACC;
    endcase
  end

  // State and handshake registers; handshake flags follow the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_ovf       <= w_ovf_next;
      r_cnt       <= w_cnt_next;
      r_in_ready  <= (w_state_next == ACC);
      r_out_valid <= (w_state_next == DONE);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sum      = r_acc;
  assign out_overflow = r_ovf;
  assign out_count    = r_cnt;

endmodule

// File: tb/tb_signed_accumulate_with_overflow.sv
// Bench: wrap and saturate instances share one stimulus stream and are checked against
// an integer-arithmetic model every cycle, plus hand-computed frame results.
module tb_signed_accumulate_with_overflow;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int HI   = 2 ** (W - 1) - 1;
  localparam int LO   = -(2 ** (W - 1));
  localparam int CMAX = 2 ** CW - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_ready;

  logic          rdy_w, vld_w, ovf_w;
  logic [W-1:0]  sum_w;
  logic [CW-1:0] cnt_w;
  logic          rdy_s, vld_s, ovf_s;
  logic [W-1:0]  sum_s;
  logic [CW-1:0] cnt_s;

  int total = 0;
  int bad   = 0;

  signed_accumulate_with_overflow #(
    .W (W), .CW (CW), .SATURATE (0)
  ) u_wrap (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (rdy_w), .in_data (in_data), .in_last (in_last),
    .out_valid (vld_w), .out_ready (out_ready),
    .out_sum (sum_w), .out_overflow (ovf_w), .out_count (cnt_w)
  );

  signed_accumulate_with_overflow #(
    .W (W), .CW (CW), .SATURATE (1)
  ) u_sat (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (rdy_s), .in_data (in_data), .in_last (in_last),
    .out_valid (vld_s), .out_ready (out_ready),
    .out_sum (sum_s), .out_overflow (ovf_s), .out_count (cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int wrap_val(input int s);
    if (s > HI) return s - 2 ** W;
    if (s < LO) return s + 2 ** W;
    return s;
  endfunction

  function automatic int sat_val(input int s);
    if (s > HI) return HI;
    if (s < LO) return LO;
    return s;
  endfunction

  function automatic bit out_of_range(input int s);
    return (s > HI) || (s < LO);
  endfunction

  int m_acc_w, m_acc_s, m_cnt;
  bit m_ovf_w, m_ovf_s, m_rdy, m_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc_w <= 0; m_acc_s <= 0; m_cnt <= 0;
      m_ovf_w <= 1'b0; m_ovf_s <= 1'b0; m_rdy <= 1'b0; m_vld <= 1'b0;
    end else if (m_vld) begin
      if (out_ready) begin
        m_acc_w <= 0; m_acc_s <= 0; m_cnt <= 0;
        m_ovf_w <= 1'b0; m_ovf_s <= 1'b0; m_vld <= 1'b0; m_rdy <= 1'b1;
      end
    end else begin
      m_rdy <= 1'b1;
      if (m_rdy && in_valid) begin
        m_acc_w <= wrap_val(m_acc_w + int'($signed(in_data)));
        m_acc_s <= sat_val(m_acc_s + int'($signed(in_data)));
        m_ovf_w <= m_ovf_w | out_of_range(m_acc_w + int'($signed(in_data)));
        m_ovf_s <= m_ovf_s | out_of_range(m_acc_s + int'($signed(in_data)));
        m_cnt   <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        if (in_last) begin
          m_vld <= 1'b1;
          m_rdy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready_wrap", rdy_w, m_rdy);
      check("model_in_ready_sat", rdy_s, m_rdy);
      check("model_out_valid_wrap", vld_w, m_vld);
      check("model_out_valid_sat", vld_s, m_vld);
      if (m_vld) begin
        check("model_sum_wrap", $signed(sum_w), m_acc_w);
        check("model_sum_sat", $signed(sum_s), m_acc_s);
        check("model_ovf_wrap", ovf_w, m_ovf_w);
        check("model_ovf_sat", ovf_s, m_ovf_s);
        check("model_count_wrap", cnt_w, m_cnt);
        check("model_count_sat", cnt_s, m_cnt);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int d, input bit last);
    bit rdy_seen;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d[W-1:0];
    in_last  = last;
    do begin
      rdy_seen = rdy_w;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy_seen && n < 20);
    check("accept", rdy_seen, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input int sw, input bit ow, input int ss,
                        input bit os, input int c);
    check({tag, "_latency"}, vld_w, 1);
    check({tag, "_sum_wrap"}, $signed(sum_w), sw);
    check({tag, "_ovf_wrap"}, ovf_w, ow);
    check({tag, "_count_wrap"}, cnt_w, c);
    check({tag, "_valid_sat"}, vld_s, 1);
    check({tag, "_sum_sat"}, $signed(sum_s), ss);
    check({tag, "_ovf_sat"}, ovf_s, os);
    check({tag, "_count_sat"}, cnt_s, c);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ready_after_release"}, rdy_w, 1);
    check({tag, "_valid_after_release"}, vld_w, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    #2;
    check("reset_in_ready", rdy_w, 0);
    check("reset_out_valid", vld_w, 0);
    check("reset_sum", sum_w, 0);
    check("reset_ovf", ovf_w, 0);
    check("reset_count", cnt_w, 0);
    check("reset_in_ready_sat", rdy_s, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_in_ready", rdy_w, 1);

    // 3 + 4: in range for both modes.
    send(3, 0); send(4, 1);
    result("plain", 7, 0, 7, 0, 2);

    // 5 + 4 overflows: wraps to -7, saturates to +7.
    send(5, 0); send(4, 1);
    result("pos_ovf", -7, 1, 7, 1, 2);

    // Saturated value keeps accumulating: 7 - 2 = 5; wrap path -7 - 2 wraps to 7.
    send(5, 0); send(4, 0); send(-2, 1);
    result("clamp_then_sub", 7, 1, 5, 1, 3);

    // -8 + -1: wraps to 7, clamps to -8.
    send(-8, 0); send(-1, 1);
    result("neg_ovf", 7, 1, -8, 1, 2);

    // Single-operand frame.
    send(-8, 1);
    result("single", -8, 0, -8, 0, 1);

    // Backpressure with a pending operand on the input.
    send(2, 0); send(2, 1);
    in_valid = 1'b1;
    in_data  = 4'd1;
    in_last  = 1'b1;
    repeat (3) begin
      check("stall_valid", vld_w, 1);
      check("stall_in_ready", rdy_w, 0);
      check("stall_sum", $signed(sum_w), 4);
      check("stall_count", cnt_w, 2);
      @(posedge clk);
      #1;
    end
    result("stalled", 4, 0, 4, 0, 2);
    send(1, 1);
    result("after_stall", 1, 0, 1, 0, 1);

    // Reset mid-frame discards the partial sum.
    send(3, 0); send(3, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", vld_w, 0);
    check("midreset_in_ready", rdy_w, 0);
    check("midreset_in_ready_sat", rdy_s, 0);
    #1 rst_n = 1'b1;
    send(1, 1);
    result("post_reset", 1, 0, 1, 0, 1);

    // Count saturates at its maximum on a long frame.
    for (int i = 0; i < 299; i++) send(0, 0);
    send(0, 1);
    result("count_sat", 0, 0, 0, 0, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
